// File: rtl/router_pkg.sv
// Shared constants for the router packet source: widths, header fields,
// destination codes and transmit FSM state encodings.
package router_pkg;

  localparam int DATA_W  = 8;
  localparam int LEN_W   = DATA_W - 2;
  localparam int MAX_LEN = (1 << LEN_W) - 1;
  localparam int GAP_MIN = 2;

  localparam int LEN_MSB  = DATA_W - 1;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  localparam logic [1:0] ADDR_ILLEGAL = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_HEADER  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for one packet: synchronous write, asynchronous read.
// Out-of-range read addresses return zero.
module router_tx_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 63,
  parameter int AW     = 6
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we && (waddr < AW'(DEPTH)))
      mem[waddr] <= wdata;
  end

  assign rdata = (raddr < AW'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers one payload, then sends
// header, payload and parity under busy back-pressure.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_W  = router_pkg::DATA_W,
  parameter int MAX_LEN = router_pkg::MAX_LEN,
  parameter int GAP_MIN = router_pkg::GAP_MIN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        dest_addr,
  input  logic [DATA_W-3:0] payload_len,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
  input  logic              err,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              tx_idle,
  output logic              cfg_err,
  output logic              done,
  output logic              pkt_err
);

  localparam int LW = DATA_W - 2;
  localparam int GW = $clog2(GAP_MIN + 1);

  logic [2:0]        state;
  logic [1:0]        addr_r;
  logic [LW-1:0]     len_r;
  logic [LW-1:0]     wr_ptr;
  logic [LW-1:0]     rd_ptr;
  logic [DATA_W-1:0] parity;
  logic [GW-1:0]     gap_cnt;
  logic              pkt_err_r;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] header;
  logic              legal;
  logic              wr_en;

  assign header   = {len_r, addr_r};
  assign legal    = (payload_len != '0) && (dest_addr != ADDR_ILLEGAL);
  assign pl_ready = (state == S_FILL);
  assign wr_en    = pl_ready && pl_valid;
  assign tx_idle  = (state == S_IDLE);
  assign done     = (state == S_DONE);
  assign pkt_err  = done && pkt_err_r;

  router_tx_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_LEN),
    .AW     (LW)
  ) u_buf (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (pl_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_r    <= '0;
      len_r     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      parity    <= '0;
      gap_cnt   <= '0;
      pkt_err_r <= 1'b0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && legal) begin
            addr_r <= dest_addr;
            len_r  <= payload_len;
            parity <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= S_FILL;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        S_FILL: begin
          if (pl_valid) begin
            wr_ptr <= wr_ptr + LW'(1);
            // header is folded into parity as it launches
            if (wr_ptr == len_r - LW'(1)) begin
              data_out  <= header;
              pkt_valid <= 1'b1;
              parity    <= parity ^ pl_data ^ header;
              state     <= S_HEADER;
            end else begin
              parity <= parity ^ pl_data;
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            data_out <= rd_data;
            rd_ptr   <= rd_ptr + LW'(1);
            state    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            if (rd_ptr == len_r) begin
              data_out  <= parity;
              pkt_valid <= 1'b0;
              state     <= S_PARITY;
            end else begin
              data_out <= rd_data;
              rd_ptr   <= rd_ptr + LW'(1);
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            gap_cnt   <= '0;
            pkt_err_r <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          pkt_err_r <= pkt_err_r | err;
          if (gap_cnt != GW'(GAP_MIN))
            gap_cnt <= gap_cnt + GW'(1);
          else if (!busy)
            state <= S_DONE;
        end
        S_DONE: begin
          data_out <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: byte stream, stalls, error
// reporting, illegal requests, max length and mid-packet reset.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] payload_len = '0;
  logic [7:0] pl_data = '0;
  logic       pl_valid = 1'b0;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       pl_ready;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_idle;
  logic       cfg_err;
  logic       done;
  logic       pkt_err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int vcnt   = 0;
  logic [7:0] pl [64];
  logic [7:0] last_par;

  router_pkt_tx dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .busy        (busy),
    .err         (err),
    .data_out    (data_out),
    .pkt_valid   (pkt_valid),
    .tx_idle     (tx_idle),
    .cfg_err     (cfg_err),
    .done        (done),
    .pkt_err     (pkt_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_pkt(input logic [1:0] a, input logic [5:0] l);
    dest_addr   = a;
    payload_len = l;
    start       = 1'b1;
    tick;
    start       = 1'b0;
  endtask

  task automatic feed(input int l);
    for (int i = 0; i < l; i++) begin
      chk("pl_ready", pl_ready, 1);
      pl_data  = pl[i];
      pl_valid = 1'b1;
      tick;
    end
    pl_valid = 1'b0;
  endtask

  task automatic xmit(input logic [7:0] hdr, input int l,
                      input int hold_at, input int hold_n);
    logic [7:0] exp;
    logic [7:0] par;
    par  = hdr;
    for (int i = 0; i < l; i++) par ^= pl[i];
    vcnt = 0;
    for (int k = 0; k <= l + 1; k++) begin
      exp = (k == 0) ? hdr : (k <= l) ? pl[k-1] : par;
      chk($sformatf("byte%0d", k), data_out, exp);
      chk($sformatf("valid%0d", k), pkt_valid, k <= l);
      if (pkt_valid) vcnt++;
      if (k == hold_at) begin
        busy = 1'b1;
        for (int j = 0; j < hold_n; j++) begin
          tick;
          chk($sformatf("hold%0d", j), data_out, exp);
          chk("hold_valid", pkt_valid, k <= l);
        end
        busy = 1'b0;
      end
      if (k == l + 1) last_par = data_out;
      if (k <= l) tick;
    end
  endtask

  task automatic wait_done(input int err_at, input logic exp_err);
    int n;
    n = 0;
    while (!done && n < 20) begin
      err = (n == err_at);
      tick;
      n++;
    end
    err = 1'b0;
    chk("done_lat", n, 4);
    chk("done", done, 1);
    chk("pkt_err", pkt_err, exp_err);
    chk("not_idle", tx_idle, 0);
    tick;
    chk("done_pulse", done, 0);
    chk("back_idle", tx_idle, 1);
    chk("dout_clr", data_out, 0);
  endtask

  task automatic load_std;
    pl[0] = 8'h11;
    pl[1] = 8'h22;
    pl[2] = 8'h33;
    pl[3] = 8'h44;
  endtask

  initial begin
    #3;
    chk("rst_dout", data_out, 0);
    chk("rst_valid", pkt_valid, 0);
    chk("rst_ready", pl_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_perr", pkt_err, 0);
    chk("rst_cfg", cfg_err, 0);
    chk("rst_idle", tx_idle, 1);
    #10 reset = 1'b0;

    // basic packet, header stalled one cycle
    load_std();
    start_pkt(2'd1, 6'd4);
    feed(4);
    xmit(8'h11, 4, 0, 1);
    chk("t1_par", last_par, 8'h55);
    wait_done(-1, 1'b0);

    // mid-payload stall; start during FILL must be ignored
    start_pkt(2'd1, 6'd4);
    start       = 1'b1;
    dest_addr   = 2'd2;
    payload_len = 6'd9;
    feed(4);
    start = 1'b0;
    xmit(8'h11, 4, 3, 5);
    chk("t2_par", last_par, 8'h55);
    wait_done(-1, 1'b0);

    // router error reported, then cleared for the next packet
    start_pkt(2'd1, 6'd4);
    feed(4);
    xmit(8'h11, 4, -1, 0);
    wait_done(2, 1'b1);
    start_pkt(2'd1, 6'd4);
    feed(4);
    xmit(8'h11, 4, -1, 0);
    wait_done(-1, 1'b0);

    // illegal requests
    start_pkt(2'd1, 6'd0);
    chk("len0_cfg", cfg_err, 1);
    chk("len0_idle", tx_idle, 1);
    chk("len0_valid", pkt_valid, 0);
    tick;
    chk("len0_pulse", cfg_err, 0);
    start_pkt(2'd3, 6'd4);
    chk("a3_cfg", cfg_err, 1);
    chk("a3_idle", tx_idle, 1);
    chk("a3_valid", pkt_valid, 0);
    pl_data  = 8'h99;
    pl_valid = 1'b1;
    tick;
    chk("a3_pulse", cfg_err, 0);
    tick;
    pl_valid = 1'b0;
    chk("idle_ready", pl_ready, 0);
    chk("idle_stay", tx_idle, 1);
    chk("idle_valid", pkt_valid, 0);

    // maximum length packet
    for (int i = 0; i < 63; i++) pl[i] = 8'hFF;
    start_pkt(2'd2, 6'd63);
    feed(63);
    xmit(8'hFE, 63, -1, 0);
    chk("t5_vcnt", vcnt, 64);
    chk("t5_par", last_par, 8'h01);
    wait_done(-1, 1'b0);

    // reset in the middle of the payload
    load_std();
    start_pkt(2'd1, 6'd4);
    feed(4);
    tick;
    tick;
    tick;
    chk("t6_b3", data_out, 8'h33);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", pkt_valid, 0);
    chk("t6_idle", tx_idle, 1);
    chk("t6_dout", data_out, 0);
    #3 reset = 1'b0;
    pl[0] = 8'hA5;
    pl[1] = 8'h5A;
    start_pkt(2'd0, 6'd2);
    feed(2);
    xmit(8'h08, 2, -1, 0);
    chk("t6_par", last_par, 8'hF7);
    wait_done(-1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
